sample_recorder: RTL
====================

# sample_recorder

Sample capture and playback stage that sits directly downstream of the sample-rate tick generator. It consumes the one-cycle sample-rate enable pulse and, on each pulse, either writes the incoming audio sample into an internal buffer (record) or emits the next stored sample (play). A small control FSM sequences record, play and stop requests from the user-input logic. Output samples go to the audio output stage.

## Interface
Parameters:
- DATA_W, 16, sample width in bits
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples
- LOOP_EN, 0, when 1, playback wraps to address 0 instead of ending

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- sample_tick  input  1  one-cycle sample-rate enable from the rate counter
- rec_req  input  1  level; start recording (sampled only in IDLE)
- play_req  input  1  level; start playback (sampled only in IDLE)
- stop  input  1  level; abort RECORD or PLAY and return to IDLE
- sample_in  input  DATA_W  sample to capture; valid whenever sample_tick=1
- sample_out  output  DATA_W  last played sample; held between ticks
- sample_valid  output  1  one-cycle pulse when sample_out updates
- busy  output  1  high in RECORD or PLAY
- full  output  1  high when length == DEPTH
- length  output  ADDR_W+1  number of valid samples stored

## Operation
- States: IDLE, RECORD, PLAY. Reset state IDLE.
- Reset values: sample_out=0, sample_valid=0, busy=0, full=0, length=0, wptr=0, rptr=0. Buffer contents are not cleared.
- IDLE:
  - rec_req=1 enters RECORD next cycle and clears length and wptr.
  - play_req=1 with length>0 enters PLAY next cycle and clears rptr.
  - play_req with length=0 is ignored.
  - rec_req and play_req together: rec_req wins.
  - sample_tick is ignored in IDLE.
- RECORD, on each sample_tick:
  - write mem[wptr] <= sample_in; wptr++; length++.
  - When the write makes length == DEPTH, go to IDLE with full=1. Further writes never occur, so there is no wrap.
- PLAY, on each sample_tick:
  - read mem[rptr]; rptr++.
  - On the tick that reads address length-1: with LOOP_EN=0, go to IDLE; with LOOP_EN=1, set rptr=0 and stay in PLAY.
- stop:
  - In RECORD or PLAY, stop=1 returns to IDLE next cycle. length keeps the count recorded so far.
  - stop and sample_tick in the same cycle: stop wins. No write occurs, and no read is issued or reported.
- rec_req and play_req are ignored outside IDLE.
- Reset mid-operation aborts at once. length=0, so an old buffer cannot be replayed.
- full clears when a new RECORD starts.

## Timing
- State transitions take effect on the edge after the request is sampled. busy rises 1 cycle after the request.
- Record: the write commits on the edge where sample_tick=1. length is visible in the next cycle.
- Play: read latency is 2 edges.
  - Edge 1 (tick cycle t) registers the address.
  - sample_out and sample_valid are registered at edge t+1.
  - sample_valid is high for exactly 1 cycle per accepted tick.
- The final sample's sample_valid pulse still occurs after the FSM has entered IDLE.
- Consecutive ticks are at least 2 cycles apart (divisor ≫ 2). Back-to-back ticks are still accepted, one sample per tick.

## Structure
- Shared package:
  - state encoding constants: IDLE=2'd0, RECORD=2'd1, PLAY=2'd2
  - DATA_W and ADDR_W defaults, shared with the rate counter and output stage
- Sub-module sample_ram: single-port synchronous RAM (DEPTH × DATA_W) with registered read and write-enable, inferable as block RAM. It has no reset. Read and write never coincide, because the modes are exclusive.
- Top level holds the FSM, wptr/rptr/length counters and the output registers.

## Test plan
- Reset and IDLE:
  - Assert reset mid-cycle → all outputs 0 asynchronously.
  - Release, then pulse sample_tick ×5 with no requests → length stays 0, no sample_valid.
- Record and play back:
  - rec_req, 4 ticks with sample_in = 0x0011, 0x0022, 0x0033, 0x0044, then stop → length=4.
  - play_req, 4 ticks → sample_out sequence 0x0011…0x0044, one sample_valid per tick at t+1.
  - FSM in IDLE after the 4th tick.
- Fill to full (ADDR_W=3 override):
  - Record 8 ticks → full=1, length=8, auto-return to IDLE.
  - 9th tick → no write; the buffer content is unchanged on playback.
- Collisions:
  - stop coincident with a tick in RECORD → length not incremented.
  - rec_req+play_req together in IDLE → RECORD entered.
  - play_req with length=0 → stays IDLE.
- Loop mode (LOOP_EN=1):
  - length=3 with values A, B, C, 7 play ticks → outputs A B C A B C A.
  - stop then returns to IDLE.
- Reset mid-PLAY:
  - Reset after 2 of 4 samples → IDLE, length=0.
  - Subsequent play_req → ignored.

Source files
------------

// File: rtl/sample_recorder_pkg.sv
// Shared definitions for the sample capture/playback path.
// The width defaults are also used by the rate counter and the output stage.
package sample_recorder_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

endpackage

// File: rtl/sample_recorder_ram.sv
// Single-port sample buffer with a registered read, written so it maps onto block RAM.
// There is no reset: stale contents are unreachable because length is cleared instead.
module sample_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sample_recorder.sv
// Record/playback stage clocked by the sample-rate tick.
// A three-state FSM steers the shared RAM port between capture and playback.
module sample_recorder
  import sample_recorder_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter bit LOOP_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic              stop,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W:0]   length
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wptr_reg, wptr_next;
  logic [ADDR_W-1:0] rptr_reg, rptr_next;
  logic [ADDR_W:0]   length_reg, length_next;
  logic              rd_pend_reg;
  logic [DATA_W-1:0] sample_out_reg;
  logic              sample_valid_reg;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_next  = state_reg;
    wptr_next   = wptr_reg;
    rptr_next   = rptr_reg;
    length_next = length_reg;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rec_req) begin
          state_next  = RECORD;
          wptr_next   = '0;
          length_next = '0;
        end else if (play_req && length_reg != '0) begin
          state_next = PLAY;
          rptr_next  = '0;
        end
      end
      RECORD: begin
        // stop outranks a coincident tick, so no partial write slips in
        if (stop) begin
          state_next = IDLE;
        end else if (sample_tick) begin
          ram_we      = 1'b1;
          wptr_next   = wptr_reg + ADDR_W'(1);
          length_next = length_reg + (ADDR_W+1)'(1);
          if (length_next == DEPTH) state_next = IDLE;
        end
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
        end else if (sample_tick) begin
          ram_re = 1'b1;
          if ({1'b0, rptr_reg} == length_reg - (ADDR_W+1)'(1)) begin
            if (LOOP_EN) rptr_next = '0;
            else         state_next = IDLE;
          end else begin
            rptr_next = rptr_reg + ADDR_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_addr = (state_reg == RECORD) ? wptr_reg : rptr_reg;

  sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (sample_in),
    .rdata (ram_rdata)
  );

  // The RAM read lands one edge after the tick; the output register adds the second edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      length_reg       <= '0;
      rd_pend_reg      <= 1'b0;
      sample_out_reg   <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      wptr_reg         <= wptr_next;
      rptr_reg         <= rptr_next;
      length_reg       <= length_next;
      rd_pend_reg      <= ram_re;
      sample_valid_reg <= rd_pend_reg;
      if (rd_pend_reg) sample_out_reg <= ram_rdata;
    end
  end

  assign sample_out   = sample_out_reg;
  assign sample_valid = sample_valid_reg;
  assign busy         = (state_reg != IDLE);
  assign full         = (length_reg == DEPTH);
  assign length       = length_reg;

endmodule
